// File: rtl/down_timer_pkg.sv
// Shared definitions for the down_timer: default width and the two FSM states.
// ST_IDLE/ST_RUN keep the same encoding as the lab's up counter.
package down_timer_pkg;

  localparam int DEFAULT_WIDTH = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/down_timer.sv
// Loadable down-counter with terminal-count strobe and optional auto-reload.
// Priority per posedge is rst > load > enab. Expiry is the enabled decrement from 1.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             load,
  input  logic             enab,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] cnt_out,
  output logic             busy,
  output logic             zero,
  output logic             tc_pulse
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  logic             tc_reg, tc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      reload_reg <= '0;
      tc_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      reload_reg <= reload_next;
      tc_reg     <= tc_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    reload_next = reload_reg;
    tc_next     = 1'b0;

    if (load) begin
      cnt_next    = cnt_in;
      reload_next = cnt_in;
      state_next  = (cnt_in != '0) ? ST_RUN : ST_IDLE;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (enab) begin
            if (cnt_reg == WIDTH'(1)) begin
              tc_next = 1'b1;
              if (auto_reload) begin
                cnt_next = reload_reg;
              end else begin
                cnt_next   = '0;
                state_next = ST_IDLE;
              end
            end else if (cnt_reg != '0) begin
              // A zero count cannot occur in RUN; guarding keeps the count from wrapping.
              cnt_next = cnt_reg - WIDTH'(1);
            end
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign cnt_out  = cnt_reg;
  assign busy     = (state_reg == ST_RUN);
  assign zero     = (cnt_reg == '0);
  assign tc_pulse = tc_reg;

endmodule

// File: tb/tb_down_timer.sv
// Scoreboard bench for down_timer: directed scenarios followed by random traffic,
// each cycle's expected outputs computed from a behavioural model and queued.
module tb_down_timer;

  localparam int W = 5;

  logic         clk;
  logic         rst;
  logic [W-1:0] cnt_in;
  logic         load;
  logic         enab;
  logic         auto_reload;
  logic [W-1:0] cnt_out;
  logic         busy;
  logic         zero;
  logic         tc_pulse;

  down_timer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cnt_in     (cnt_in),
    .load       (load),
    .enab       (enab),
    .auto_reload(auto_reload),
    .cnt_out    (cnt_out),
    .busy       (busy),
    .zero       (zero),
    .tc_pulse   (tc_pulse)
  );

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         busy;
    logic         tc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  // Behavioural model state
  int m_cnt    = 0;
  int m_period = 0;
  bit m_run    = 0;
  bit m_tc     = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL txn %0d %s actual %0d required %0d", txn, name, act, req);
    end
  endtask

  // Monitor: every posedge the DUT presents a new output set; compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        check("cnt_out", int'(cnt_out), int'(e.cnt));
        check("busy", int'(busy), int'(e.busy));
        check("zero", int'(zero), (e.cnt == 0) ? 1 : 0);
        check("tc_pulse", int'(tc_pulse), int'(e.tc));
        $display("txn %0d cnt_out=%0d busy=%0b zero=%0b tc=%0b exp_cnt=%0d exp_busy=%0b exp_tc=%0b",
                 txn, cnt_out, busy, zero, tc_pulse, e.cnt, e.busy, e.tc);
      end
    end
  end

  // One cycle of stimulus: drive on the falling edge, advance the model, queue the result.
  task automatic step(input bit r, input bit ld, input int cin, input bit en, input bit ar);
    exp_t e;
    @(negedge clk);
    rst         = r;
    load        = ld;
    cnt_in      = W'(cin);
    enab        = en;
    auto_reload = ar;
    if (r) begin
      m_cnt = 0; m_period = 0; m_run = 0; m_tc = 0;
    end else if (ld) begin
      m_cnt = cin; m_period = cin; m_run = (cin != 0); m_tc = 0;
    end else if (m_run && en && m_cnt == 1) begin
      m_tc = 1;
      if (ar) m_cnt = m_period;
      else begin
        m_cnt = 0;
        m_run = 0;
      end
    end else if (m_run && en) begin
      m_cnt = m_cnt - 1;
      m_tc  = 0;
    end else begin
      m_tc = 0;
    end
    e.cnt  = W'(m_cnt);
    e.busy = m_run;
    e.tc   = m_tc;
    exp_q.push_back(e);
  endtask

  initial begin
    int wait_cycles;
    rst = 1'b1; load = 1'b1; cnt_in = W'(9); enab = 1'b0; auto_reload = 1'b0;

    // Reset held two cycles while load is requested
    step(1, 1, 9, 0, 0);
    step(1, 1, 9, 1, 0);

    // Basic count from 3, enable continuous, then extra enables at zero
    step(0, 1, 3, 0, 0);
    repeat (6) step(0, 0, 0, 1, 0);

    // Enable gaps from 4
    step(0, 1, 4, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, (i % 2 == 0), 0);

    // Auto-reload period 2, then drop auto_reload
    step(0, 1, 2, 0, 1);
    repeat (7) step(0, 0, 0, 1, 1);
    repeat (3) step(0, 0, 0, 1, 0);

    // Period 1 with auto-reload: strobe every cycle
    step(0, 1, 1, 0, 1);
    repeat (4) step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);

    // Load colliding with expiry, then load 0
    step(0, 1, 2, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 31, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // Reset mid-run, then normal restart
    step(0, 1, 10, 0, 0);
    repeat (4) step(0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 5, 0, 0);
    repeat (7) step(0, 0, 0, 1, 0);

    // Random traffic with small periods so expiries are frequent
    for (int i = 0; i < 400; i++) begin
      bit r, ld, en, ar;
      int cin;
      r   = ($urandom_range(0, 39) == 0);
      ld  = ($urandom_range(0, 7) == 0);
      cin = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 4);
      en  = ($urandom_range(0, 3) != 0);
      ar  = ($urandom_range(0, 1) == 1);
      step(r, ld, cin, en, ar);
    end

    @(negedge clk);
    load = 1'b0; enab = 1'b0; rst = 1'b0;
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(negedge clk);
      wait_cycles++;
    end
    check("drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
